// File: rtl/brv32p_pkg.sv
// Shared definitions for the cache-side AXI4-Lite initiator.
package brv32p_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        DONE
    } axil_mst_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // SLVERR and DECERR are failures; OKAY and EXOKAY are not.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/cache_axil_master_if.sv
// AXI4-Lite bus bundle between the cache initiator and the interconnect.
interface cache_axil_master_if;
    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;
    logic [31:0] m_awaddr;
    logic        m_awvalid;
    logic        m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;

    modport master (
        output m_araddr, m_arvalid, m_rready, m_awaddr, m_awvalid,
               m_wdata, m_wstrb, m_wvalid, m_bready,
        input  m_arready, m_rdata, m_rresp, m_rvalid, m_awready,
               m_wready, m_bresp, m_bvalid
    );

    modport slave (
        input  m_araddr, m_arvalid, m_rready, m_awaddr, m_awvalid,
               m_wdata, m_wstrb, m_wvalid, m_bready,
        output m_arready, m_rdata, m_rresp, m_rvalid, m_awready,
               m_wready, m_bresp, m_bvalid
    );
endinterface

// File: rtl/cache_axil_master.sv
// Converts a level-held cache mem_rd/mem_wr request into one AXI4-Lite
// transaction at a time, with a watchdog that forces an error completion.
module cache_axil_master
    import brv32p_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                mem_addr,
    input  logic                       mem_rd,
    input  logic                       mem_wr,
    input  logic [31:0]                mem_wdata,
    input  logic [3:0]                 mem_wstrb,
    output logic [31:0]                mem_rdata,
    output logic                       mem_valid,
    output logic                       mem_err,
    output logic                       mem_busy,
    cache_axil_master_if.master        axi
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

    axil_mst_state_e state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic        aw_done, aw_done_next, w_done, w_done_next;
    logic [31:0] araddr, araddr_next, awaddr, awaddr_next, wdata, wdata_next;
    logic [3:0]  wstrb, wstrb_next;
    logic        arvalid, arvalid_next, rready, rready_next;
    logic        awvalid, awvalid_next, wvalid, wvalid_next, bready, bready_next;
    logic [31:0] rdata, rdata_next;
    logic        valid, valid_next, err, err_next;
    logic        timeout, aw_hit, w_hit;

    assign timeout = WD_EN && (cnt == CNT_LIMIT);
    assign aw_hit  = awvalid && axi.m_awready;
    assign w_hit   = wvalid && axi.m_wready;

    // Next state, next registered outputs, watchdog and write-acceptance flags.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        aw_done_next = aw_done;
        w_done_next  = w_done;
        araddr_next  = araddr;
        awaddr_next  = awaddr;
        wdata_next   = wdata;
        wstrb_next   = wstrb;
        arvalid_next = arvalid;
        rready_next  = rready;
        awvalid_next = awvalid;
        wvalid_next  = wvalid;
        bready_next  = bready;
        rdata_next   = rdata;
        valid_next   = 1'b0;
        err_next     = 1'b0;

        case (state)
            IDLE:    cnt_next = '0;
            DONE:    cnt_next = cnt;
            default: cnt_next = cnt + 1'b1;
        endcase

        if (state != IDLE && state != DONE && timeout) begin
            // Abandon the transaction: drop every valid/ready, report an error.
            // Read data is zeroed only for reads so mem_rdata keeps its
            // last read value across writes.
            arvalid_next = 1'b0;
            rready_next  = 1'b0;
            awvalid_next = 1'b0;
            wvalid_next  = 1'b0;
            bready_next  = 1'b0;
            if (state == RD_ADDR || state == RD_DATA) begin
                rdata_next = '0;
            end
            valid_next = 1'b1;
            err_next   = 1'b1;
            state_next = DONE;
        end else begin
            case (state)
                IDLE: begin
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                    if (mem_wr) begin
                        awaddr_next  = {mem_addr[31:2], 2'b00};
                        wdata_next   = mem_wdata;
                        wstrb_next   = mem_wstrb;
                        awvalid_next = 1'b1;
                        wvalid_next  = 1'b1;
                        state_next   = WR_REQ;
                    end else if (mem_rd) begin
                        araddr_next  = {mem_addr[31:2], 2'b00};
                        arvalid_next = 1'b1;
                        state_next   = RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    if (axi.m_arready) begin
                        arvalid_next = 1'b0;
                        rready_next  = 1'b1;
                        state_next   = RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (axi.m_rvalid) begin
                        rready_next = 1'b0;
                        rdata_next  = axi.m_rdata;
                        valid_next  = 1'b1;
                        err_next    = resp_is_err(axi.m_rresp);
                        state_next  = DONE;
                    end
                end
                WR_REQ: begin
                    aw_done_next = aw_done || aw_hit;
                    w_done_next  = w_done || w_hit;
                    if (aw_hit) awvalid_next = 1'b0;
                    if (w_hit)  wvalid_next  = 1'b0;
                    if (aw_done_next && w_done_next) begin
                        bready_next = 1'b1;
                        state_next  = WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (axi.m_bvalid) begin
                        bready_next = 1'b0;
                        valid_next  = 1'b1;
                        err_next    = resp_is_err(axi.m_bresp);
                        state_next  = DONE;
                    end
                end
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // State and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            araddr  <= '0;
            awaddr  <= '0;
            wdata   <= '0;
            wstrb   <= '0;
            arvalid <= 1'b0;
            rready  <= 1'b0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
            rdata   <= '0;
            valid   <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            aw_done <= aw_done_next;
            w_done  <= w_done_next;
            araddr  <= araddr_next;
            awaddr  <= awaddr_next;
            wdata   <= wdata_next;
            wstrb   <= wstrb_next;
            arvalid <= arvalid_next;
            rready  <= rready_next;
            awvalid <= awvalid_next;
            wvalid  <= wvalid_next;
            bready  <= bready_next;
            rdata   <= rdata_next;
            valid   <= valid_next;
            err     <= err_next;
        end
    end

    assign axi.m_araddr  = araddr;
    assign axi.m_arvalid = arvalid;
    assign axi.m_rready  = rready;
    assign axi.m_awaddr  = awaddr;
    assign axi.m_awvalid = awvalid;
    assign axi.m_wdata   = wdata;
    assign axi.m_wstrb   = wstrb;
    assign axi.m_wvalid  = wvalid;
    assign axi.m_bready  = bready;
    assign mem_rdata     = rdata;
    assign mem_valid     = valid;
    assign mem_err       = err;
    assign mem_busy      = (state != IDLE);

endmodule

// File: tb/tb_cache_axil_master.sv
// Self-checking bench: the bench plays both the cache requester and a
// scripted AXI4-Lite slave, and predicts every output cycle from the
// handshake timing rules.
module tb_cache_axil_master;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rd, mem_wr, mem_valid, mem_err, mem_busy;
    logic [3:0]  mem_wstrb;

    int total = 0;
    int bad   = 0;

    logic [31:0] model_rdata;
    int          obs_t, obs_err, aw_cnt, w_cnt;
    logic [31:0] obs_addr;

    typedef struct {
        bit          wr;
        bit          also_rd;
        bit          hang;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  wstrb;
        logic [1:0]  resp;
        int          da;
        int          dw;
        int          dr;
    } tx_t;

    cache_axil_master_if bus ();

    cache_axil_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid),
        .mem_err   (mem_err),
        .mem_busy  (mem_busy),
        .axi       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
        end
    endtask

    task automatic slave_quiet();
        bus.m_arready = 1'b0;
        bus.m_rvalid  = 1'b0;
        bus.m_rdata   = $urandom;
        bus.m_rresp   = 2'($urandom_range(0, 3));
        bus.m_awready = 1'b0;
        bus.m_wready  = 1'b0;
        bus.m_bvalid  = 1'b0;
        bus.m_bresp   = 2'($urandom_range(0, 3));
    endtask

    task automatic check_reset_vals();
        chk("rst_arvalid", 32'(bus.m_arvalid), 0);
        chk("rst_rready",  32'(bus.m_rready), 0);
        chk("rst_awvalid", 32'(bus.m_awvalid), 0);
        chk("rst_wvalid",  32'(bus.m_wvalid), 0);
        chk("rst_bready",  32'(bus.m_bready), 0);
        chk("rst_valid",   32'(mem_valid), 0);
        chk("rst_err",     32'(mem_err), 0);
        chk("rst_busy",    32'(mem_busy), 0);
        chk("rst_rdata",   mem_rdata, 0);
        chk("rst_araddr",  bus.m_araddr, 0);
        chk("rst_awaddr",  bus.m_awaddr, 0);
        chk("rst_wdata",   bus.m_wdata, 0);
        chk("rst_wstrb",   32'(bus.m_wstrb), 0);
    endtask

    // Idle cycles: nothing requested, every output must be quiet.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            chk("idle_arvalid", 32'(bus.m_arvalid), 0);
            chk("idle_awvalid", 32'(bus.m_awvalid), 0);
            chk("idle_wvalid",  32'(bus.m_wvalid), 0);
            chk("idle_valid",   32'(mem_valid), 0);
            chk("idle_busy",    32'(mem_busy), 0);
            chk("idle_rdata",   mem_rdata, model_rdata);
            mem_rd = 1'b0;
            mem_wr = 1'b0;
            slave_quiet();
            @(negedge clk);
        end
    endtask

    // One transaction. At each negedge (cycle t after the request cycle t=0)
    // outputs are checked against the timing rules, then inputs for cycle t
    // are driven. Slave ready/valid timing is scripted by the delays in p.
    task automatic run_tx(input tx_t p);
        int m, lim;
        logic [31:0] ea;
        bit arv_e, rr_e, awv_e, wv_e, br_e;
        ea  = {p.addr[31:2], 2'b00};
        m   = p.wr ? ((p.da > p.dw) ? p.da : p.dw) : p.da;
        lim = p.hang ? (TO + 1) : (3 + m + p.dr);
        obs_t = -1; obs_err = -1; aw_cnt = 0; w_cnt = 0; obs_addr = 'x;
        for (int t = 0; t <= lim; t++) begin
            arv_e = !p.wr && t >= 1 && (p.hang ? (t <= TO) : (t <= 1 + p.da));
            rr_e  = !p.wr && !p.hang && t >= 2 + p.da && t <= 2 + p.da + p.dr;
            awv_e = p.wr && t >= 1 && t <= 1 + p.da;
            wv_e  = p.wr && t >= 1 && t <= 1 + p.dw;
            br_e  = p.wr && t >= 2 + m && t <= 2 + m + p.dr;
            if (t == lim && !p.wr) model_rdata = p.hang ? 32'h0 : p.rdata;

            chk("arvalid", 32'(bus.m_arvalid), 32'(arv_e));
            chk("rready",  32'(bus.m_rready),  32'(rr_e));
            chk("awvalid", 32'(bus.m_awvalid), 32'(awv_e));
            chk("wvalid",  32'(bus.m_wvalid),  32'(wv_e));
            chk("bready",  32'(bus.m_bready),  32'(br_e));
            chk("valid",   32'(mem_valid), 32'(t == lim));
            chk("busy",    32'(mem_busy),  32'(t >= 1));
            chk("rdata",   mem_rdata, model_rdata);
            if (arv_e) chk("araddr", bus.m_araddr, ea);
            if (awv_e) chk("awaddr", bus.m_awaddr, ea);
            if (wv_e) begin
                chk("wdata", bus.m_wdata, p.wdata);
                chk("wstrb", 32'(bus.m_wstrb), 32'(p.wstrb));
            end
            if (t == lim) chk("err", 32'(mem_err), p.hang ? 32'd1 : 32'(p.resp[1]));

            if (mem_valid === 1'b1 && obs_t < 0) begin
                obs_t = t;
                obs_err = int'(mem_err);
            end
            if (bus.m_awvalid === 1'b1) aw_cnt++;
            if (bus.m_wvalid === 1'b1) w_cnt++;
            if (t == 1) obs_addr = p.wr ? bus.m_awaddr : bus.m_araddr;

            slave_quiet();
            if (t == 0) begin
                mem_addr  = p.addr;
                mem_wdata = p.wdata;
                mem_wstrb = p.wstrb;
            end else begin
                // Scramble request fields: the bridge must use its captured copy.
                mem_addr  = $urandom;
                mem_wdata = $urandom;
                mem_wstrb = 4'($urandom_range(0, 15));
            end
            mem_wr = (t < lim) && p.wr;
            mem_rd = (t < lim) && (!p.wr || p.also_rd);
            if (!p.hang) begin
                bus.m_arready = !p.wr && t == 1 + p.da;
                bus.m_awready = p.wr && t == 1 + p.da;
                bus.m_wready  = p.wr && t == 1 + p.dw;
                if (!p.wr && t == 2 + p.da + p.dr) begin
                    bus.m_rvalid = 1'b1;
                    bus.m_rdata  = p.rdata;
                    bus.m_rresp  = p.resp;
                end
                if (p.wr && t == 2 + m + p.dr) begin
                    bus.m_bvalid = 1'b1;
                    bus.m_bresp  = p.resp;
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        tx_t p;
        rst = 1'b1;
        mem_rd = 1'b0; mem_wr = 1'b0;
        mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        slave_quiet();
        model_rdata = '0;
        repeat (2) @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        idle(2);

        // Zero-wait read of 0x104.
        p = '{wr:0, also_rd:0, hang:0, addr:32'h0000_0104, wdata:0, rdata:32'hDEADBEEF,
              wstrb:0, resp:2'b00, da:0, dw:0, dr:0};
        run_tx(p);
        chk("lit_rd_araddr",  obs_addr, 32'h0000_0104);
        chk("lit_rd_latency", 32'(obs_t), 32'd3);
        chk("lit_rd_err",     32'(obs_err), 32'd0);
        chk("lit_rd_rdata",   mem_rdata, 32'hDEADBEEF);
        idle(1);

        // Write with awready delayed 3 cycles, wready immediate.
        p = '{wr:1, also_rd:0, hang:0, addr:32'h2000_0003, wdata:32'h0000_1234, rdata:0,
              wstrb:4'b0011, resp:2'b00, da:3, dw:0, dr:0};
        run_tx(p);
        chk("lit_wr_awaddr",  obs_addr, 32'h2000_0000);
        chk("lit_wr_awcnt",   32'(aw_cnt), 32'd4);
        chk("lit_wr_wcnt",    32'(w_cnt), 32'd1);
        chk("lit_wr_latency", 32'(obs_t), 32'd6);

        // Simultaneous read and write: write served, no AR issued.
        p = '{wr:1, also_rd:1, hang:0, addr:32'h0000_0040, wdata:32'hCAFE0001, rdata:0,
              wstrb:4'hF, resp:2'b00, da:0, dw:1, dr:1};
        run_tx(p);
        chk("lit_both_latency", 32'(obs_t), 32'd5);

        // Read answered with SLVERR.
        p = '{wr:0, also_rd:0, hang:0, addr:32'h0000_0200, wdata:0, rdata:32'h5555_AAAA,
              wstrb:0, resp:2'b10, da:1, dw:0, dr:2};
        run_tx(p);
        chk("lit_slverr_err", 32'(obs_err), 32'd1);
        idle(2);

        // Slave never accepts the read address.
        p = '{wr:0, also_rd:0, hang:1, addr:32'h0000_0300, wdata:0, rdata:0,
              wstrb:0, resp:2'b00, da:0, dw:0, dr:0};
        run_tx(p);
        chk("lit_to_cycles", 32'(obs_t), 32'd17);
        chk("lit_to_err",    32'(obs_err), 32'd1);
        chk("lit_to_rdata",  mem_rdata, 32'h0);
        idle(3);

        // Randomized traffic with short stalls.
        for (int n = 0; n < 60; n++) begin
            p.wr      = 1'($urandom_range(0, 1));
            p.also_rd = 1'($urandom_range(0, 1));
            p.hang    = 1'b0;
            p.addr    = $urandom;
            p.wdata   = $urandom;
            p.rdata   = $urandom;
            p.wstrb   = 4'($urandom_range(0, 15));
            p.resp    = 2'($urandom_range(0, 3));
            p.da      = $urandom_range(0, 3);
            p.dw      = $urandom_range(0, 3);
            p.dr      = $urandom_range(0, 3);
            run_tx(p);
            idle($urandom_range(0, 2));
        end

        // Reset asserted while waiting for the write response.
        mem_addr = 32'h0000_0500; mem_wdata = 32'h1111_2222; mem_wstrb = 4'hF;
        mem_wr = 1'b1;
        @(negedge clk);
        chk("mid_awvalid", 32'(bus.m_awvalid), 1);
        bus.m_awready = 1'b1;
        bus.m_wready  = 1'b1;
        @(negedge clk);
        chk("mid_bready", 32'(bus.m_bready), 1);
        slave_quiet();
        rst = 1'b1;
        #1;
        check_reset_vals();
        model_rdata = '0;
        mem_wr = 1'b0;
        @(negedge clk);
        chk("mid_no_valid", 32'(mem_valid), 0);
        rst = 1'b0;
        idle(1);
        p = '{wr:0, also_rd:0, hang:0, addr:32'h0000_0604, wdata:0, rdata:32'h0BAD_F00D,
              wstrb:0, resp:2'b00, da:1, dw:0, dr:0};
        run_tx(p);
        chk("lit_post_rst_rdata", mem_rdata, 32'h0BAD_F00D);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
